// File: rtl/fft_pkg.sv
// Shared FFT datapath package: Q16.16 format constants,
// complex sample type and the 32-bit saturation helper.
package fft_pkg;

    localparam int FRAC_BITS = 16;
    localparam int DW        = 32;

    localparam logic [DW-1:0] ONE     = 32'h0001_0000;
    localparam logic [DW-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DW-1:0] SAT_MIN = 32'h8000_0000;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cpx_t;

    // Clamp a 66-bit signed value to 32 bits; MSB of result is the flag.
    function automatic logic [DW:0] sat_word(input logic [2*DW+1:0] v);
        if (&v[2*DW+1:DW-1] || ~|v[2*DW+1:DW-1])
            return {1'b0, v[DW-1:0]};
        return {1'b1, v[2*DW+1] ? SAT_MIN : SAT_MAX};
    endfunction

endpackage

// File: rtl/ifft_butterfly_if.sv
// Handshake and data bundle of the inverse butterfly:
// sequencer side (in_*) and output-buffer side (out_*).
interface ifft_butterfly_if;
    import fft_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] x_re, x_im;
    logic [DW-1:0] y_re, y_im;
    logic [DW-1:0] w_re, w_im;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] top_re, top_im;
    logic [DW-1:0] bot_re, bot_im;
    logic          sat;

    modport master (
        output in_valid, x_re, x_im, y_re, y_im, w_re, w_im, out_ready,
        input  in_ready, out_valid, top_re, top_im, bot_re, bot_im, sat
    );

    modport slave (
        input  in_valid, x_re, x_im, y_re, y_im, w_re, w_im, out_ready,
        output in_ready, out_valid, top_re, top_im, bot_re, bot_im, sat
    );

endinterface

// File: rtl/ifft_butterfly_cmul.sv
// Combinational t = y * conj(W) in Q16.16 with floor shift,
// per-component saturation and a combined saturation flag.
module cmul_conj
    import fft_pkg::*;
(
    input  cpx_t y_i,
    input  cpx_t w_i,
    output cpx_t t_o,
    output logic sat_o
);

    logic signed [2*DW-1:0] p_rr, p_ii, p_ir, p_ri;
    logic signed [2*DW+1:0] s_re, s_im;
    logic        [2*DW+1:0] sh_re, sh_im;
    logic        [DW:0]     c_re, c_im;

    assign p_rr = (2*DW)'($signed(y_i.re)) * (2*DW)'($signed(w_i.re));
    assign p_ii = (2*DW)'($signed(y_i.im)) * (2*DW)'($signed(w_i.im));
    assign p_ir = (2*DW)'($signed(y_i.im)) * (2*DW)'($signed(w_i.re));
    assign p_ri = (2*DW)'($signed(y_i.re)) * (2*DW)'($signed(w_i.im));

    assign s_re = (2*DW+2)'(p_rr) + (2*DW+2)'(p_ii);
    assign s_im = (2*DW+2)'(p_ir) - (2*DW+2)'(p_ri);

    assign sh_re = s_re >>> FRAC_BITS;
    assign sh_im = s_im >>> FRAC_BITS;

    assign c_re = sat_word(sh_re);
    assign c_im = sat_word(sh_im);

    assign t_o   = '{re: c_re[DW-1:0], im: c_im[DW-1:0]};
    assign sat_o = c_re[DW] | c_im[DW];

endmodule

// File: rtl/ifft_butterfly.sv
// Two-stage inverse radix-2 butterfly: multiply stage then
// halved add/sub into the output registers, valid/ready both sides.
module ifft_butterfly
    import fft_pkg::*;
(
    input logic             clk,
    input logic             rst,
    ifft_butterfly_if.slave bus
);

    cpx_t x_in, y_in, w_in, t_d;
    cpx_t x1_q, t1_q;
    cpx_t top_d, bot_d, top_q, bot_q;
    logic sat_d, s1_q, v1_q, ov_q, sat_q;
    logic advance;
    logic [DW:0] sum_re, sum_im, dif_re, dif_im;

    assign x_in = '{re: bus.x_re, im: bus.x_im};
    assign y_in = '{re: bus.y_re, im: bus.y_im};
    assign w_in = '{re: bus.w_re, im: bus.w_im};

    assign advance      = !ov_q || bus.out_ready;
    assign bus.in_ready = advance;

    cmul_conj u_cmul (
        .y_i   (y_in),
        .w_i   (w_in),
        .t_o   (t_d),
        .sat_o (sat_d)
    );

    // Stage 1: capture t and the delayed x whenever the pipe moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            s1_q <= 1'b0;
            x1_q <= '0;
            t1_q <= '0;
        end else if (advance) begin
            v1_q <= bus.in_valid;
            s1_q <= sat_d;
            x1_q <= x_in;
            t1_q <= t_d;
        end
    end

    // Stage 2 datapath: 33-bit sum/difference, halved with floor.
    always_comb begin
        sum_re = {x1_q.re[DW-1], x1_q.re} + {t1_q.re[DW-1], t1_q.re};
        sum_im = {x1_q.im[DW-1], x1_q.im} + {t1_q.im[DW-1], t1_q.im};
        dif_re = {x1_q.re[DW-1], x1_q.re} - {t1_q.re[DW-1], t1_q.re};
        dif_im = {x1_q.im[DW-1], x1_q.im} - {t1_q.im[DW-1], t1_q.im};
        top_d  = '{re: DW'(sum_re >> 1), im: DW'(sum_im >> 1)};
        bot_d  = '{re: DW'(dif_re >> 1), im: DW'(dif_im >> 1)};
    end

    // Output registers hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q  <= 1'b0;
            sat_q <= 1'b0;
            top_q <= '0;
            bot_q <= '0;
        end else if (advance) begin
            ov_q  <= v1_q;
            sat_q <= s1_q;
            top_q <= top_d;
            bot_q <= bot_d;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.sat       = sat_q;
    assign bus.top_re    = top_q.re;
    assign bus.top_im    = top_q.im;
    assign bus.bot_re    = bot_q.re;
    assign bus.bot_im    = bot_q.im;

endmodule

// File: tb/tb_ifft_butterfly.sv
// Self-checking bench for ifft_butterfly: directed spec vectors
// plus randomized streams against a wide-integer reference model.
module tb_ifft_butterfly;
    import fft_pkg::*;

    typedef struct packed {
        logic [DW-1:0] tr, ti, br, bi;
        logic          s;
    } res_t;

    localparam logic signed [127:0] MAXV = 128'sd2147483647;
    localparam logic signed [127:0] MINV = -128'sd2147483648;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    ifft_butterfly_if bus ();

    ifft_butterfly dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: exact integer math, floor division, then clamp.
    function automatic res_t model(input cpx_t x, input cpx_t y, input cpx_t w);
        logic signed [127:0] xr, xi, yr, yi, wr, wi, tr, ti, a;
        res_t r;
        xr = 128'($signed(x.re)); xi = 128'($signed(x.im));
        yr = 128'($signed(y.re)); yi = 128'($signed(y.im));
        wr = 128'($signed(w.re)); wi = 128'($signed(w.im));
        tr = (yr * wr + yi * wi) >>> 16;
        ti = (yi * wr - yr * wi) >>> 16;
        r.s = 1'b0;
        if (tr > MAXV) begin tr = MAXV; r.s = 1'b1; end
        if (tr < MINV) begin tr = MINV; r.s = 1'b1; end
        if (ti > MAXV) begin ti = MAXV; r.s = 1'b1; end
        if (ti < MINV) begin ti = MINV; r.s = 1'b1; end
        a = (xr + tr) >>> 1; r.tr = a[31:0];
        a = (xi + ti) >>> 1; r.ti = a[31:0];
        a = (xr - tr) >>> 1; r.br = a[31:0];
        a = (xi - ti) >>> 1; r.bi = a[31:0];
        return r;
    endfunction

    function automatic res_t get_out();
        return {bus.top_re, bus.top_im, bus.bot_re, bus.bot_im, bus.sat};
    endfunction

    function automatic cpx_t rnd_cpx();
        logic [31:0] a, b;
        cpx_t c;
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 2))
            0:       c = '{re: a, im: b};
            1:       c = '{re: {{13{a[18]}}, a[18:0]}, im: {{13{b[18]}}, b[18:0]}};
            default: c = '{re: {{16{a[15]}}, a[15:0]}, im: {{16{b[15]}}, b[15:0]}};
        endcase
        return c;
    endfunction

    task automatic drive(input logic v, input cpx_t x, input cpx_t y, input cpx_t w);
        bus.in_valid = v;
        bus.x_re = x.re; bus.x_im = x.im;
        bus.y_re = y.re; bus.y_im = y.im;
        bus.w_re = w.re; bus.w_im = w.im;
    endtask

    // Send one input on an empty pipe and wait for its result.
    task automatic run_single(input cpx_t x, input cpx_t y, input cpx_t w,
                              output res_t got, output int lat);
        got = '0;
        lat = -1;
        bus.out_ready = 1'b1;
        drive(1'b1, x, y, w);
        @(posedge clk); #1;
        drive(1'b0, x, y, w);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = get_out();
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        cpx_t z;
        z = '0;
        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b0, z, z, z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        nvec++;
        if (bus.in_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        nvec++;
        if (get_out() !== '0) begin
            nerr++; $display("FAIL reset_outputs got=%h exp=0", get_out());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_release got=%b exp=0", bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        cpx_t x, y, w;
        res_t got, req;
        int   lat;
        x = '{re: 32'h0002_0000, im: 32'h0};
        y = '{re: 32'h0001_0000, im: 32'h0001_0000};
        w = '{re: ONE, im: 32'h0};
        req = {32'h0001_8000, 32'h0000_8000, 32'h0000_8000, 32'hFFFF_8000, 1'b0};
        run_single(x, y, w, got, lat);
        nvec++;
        if (lat !== 2) begin
            nerr++; $display("FAIL basic_latency got=%0d exp=2", lat);
        end
        nvec++;
        if (got !== req) begin
            nerr++; $display("FAIL basic_value got=%h exp=%h", got, req);
        end
        nvec++;
        if (got !== model(x, y, w)) begin
            nerr++; $display("FAIL basic_model got=%h exp=%h", got, model(x, y, w));
        end
    endtask

    task automatic test_conj();
        cpx_t x, y, w;
        res_t got, req;
        int   lat;
        x = '0;
        y = '{re: ONE, im: 32'h0};
        w = '{re: 32'h0, im: ONE};
        req = {32'h0, 32'hFFFF_8000, 32'h0, 32'h0000_8000, 1'b0};
        run_single(x, y, w, got, lat);
        nvec++;
        if (got !== req) begin
            nerr++; $display("FAIL conj_value got=%h exp=%h lat=%0d", got, req, lat);
        end
    endtask

    task automatic test_sat();
        cpx_t x, y, w;
        res_t got, req;
        int   lat;
        x = '0;
        y = '{re: 32'h7FFF_FFFF, im: 32'h0};
        w = '{re: 32'h0002_0000, im: 32'h0};
        req = {32'h3FFF_FFFF, 32'h0, 32'hC000_0000, 32'h0, 1'b1};
        run_single(x, y, w, got, lat);
        nvec++;
        if (got !== req) begin
            nerr++; $display("FAIL sat_value got=%h exp=%h lat=%0d", got, req, lat);
        end
        nvec++;
        if (got !== model(x, y, w)) begin
            nerr++; $display("FAIL sat_model got=%h exp=%h", got, model(x, y, w));
        end
    endtask

    task automatic test_backpressure();
        cpx_t xs[4], ys[4], ws[4];
        res_t exp_q[$];
        res_t prev, e;
        logic stall_prev, exp_rdy;
        int   sent, rcvd;
        sent = 0; rcvd = 0; stall_prev = 1'b0; prev = '0;
        for (int i = 0; i < 4; i++) begin
            xs[i] = rnd_cpx(); ys[i] = rnd_cpx(); ws[i] = rnd_cpx();
        end
        for (int c = 0; c < 40 && rcvd < 4; c++) begin
            bus.out_ready = (c >= 3);
            if (sent < 4) drive(1'b1, xs[sent], ys[sent], ws[sent]);
            else          drive(1'b0, xs[0], ys[0], ws[0]);
            @(negedge clk);
            if (stall_prev) begin
                nvec++;
                if (!bus.out_valid || get_out() !== prev) begin
                    nerr++; $display("FAIL bp_stable got=%h exp=%h", get_out(), prev);
                end
            end
            exp_rdy = bus.out_ready || (sent - rcvd) < 2;
            nvec++;
            if (bus.in_ready !== exp_rdy) begin
                nerr++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy);
            end
            if (c == 3) begin
                nvec++;
                if (sent != 2) begin
                    nerr++; $display("FAIL bp_capacity got=%0d exp=2", sent);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
                nvec++;
                if (get_out() !== e) begin
                    nerr++; $display("FAIL bp_data idx=%0d got=%h exp=%h", rcvd, get_out(), e);
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(xs[sent], ys[sent], ws[sent]));
                sent++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev = get_out();
            @(posedge clk); #1;
        end
        drive(1'b0, xs[0], ys[0], ws[0]);
        nvec++;
        if (rcvd != 4) begin
            nerr++; $display("FAIL bp_count got=%0d exp=4", rcvd);
        end
        @(negedge clk);
        nvec++;
        if (bus.out_valid !== 1'b0) begin
            nerr++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        cpx_t xs[16], ys[16], ws[16];
        res_t exp_q[$];
        res_t e;
        int   sent, rcvd;
        sent = 0; rcvd = 0;
        for (int i = 0; i < 16; i++) begin
            xs[i] = rnd_cpx(); ys[i] = rnd_cpx(); ws[i] = rnd_cpx();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && rcvd < 16; c++) begin
            if (sent < 16) drive(1'b1, xs[sent], ys[sent], ws[sent]);
            else           drive(1'b0, xs[0], ys[0], ws[0]);
            @(negedge clk);
            if (bus.in_valid) begin
                nvec++;
                if (bus.in_ready !== 1'b1) begin
                    nerr++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", c, bus.in_ready);
                end
            end
            if (bus.out_valid) begin
                nvec++;
                if (c != rcvd + 2) begin
                    nerr++; $display("FAIL b2b_timing idx=%0d got_cyc=%0d exp_cyc=%0d", rcvd, c, rcvd + 2);
                end
                e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
                nvec++;
                if (get_out() !== e) begin
                    nerr++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", rcvd, get_out(), e);
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(xs[sent], ys[sent], ws[sent]));
                sent++;
            end
            @(posedge clk); #1;
        end
        drive(1'b0, xs[0], ys[0], ws[0]);
        nvec++;
        if (rcvd != 16) begin
            nerr++; $display("FAIL b2b_count got=%0d exp=16", rcvd);
        end
    endtask

    task automatic test_random_flow();
        cpx_t x, y, w;
        res_t exp_q[$];
        res_t e;
        int   sent, rcvd;
        sent = 0; rcvd = 0;
        x = rnd_cpx(); y = rnd_cpx(); w = rnd_cpx();
        for (int c = 0; c < 200 && (c < 80 || exp_q.size() > 0); c++) begin
            bus.out_ready = ($urandom_range(0, 2) != 0) || c >= 80;
            drive((c < 80) && ($urandom_range(0, 3) != 0), x, y, w);
            @(negedge clk);
            if (bus.out_ready || !bus.out_valid) begin
                nvec++;
                if (bus.in_ready !== 1'b1) begin
                    nerr++; $display("FAIL rf_in_ready cyc=%0d got=%b exp=1", c, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
                nvec++;
                if (get_out() !== e) begin
                    nerr++; $display("FAIL rf_data idx=%0d got=%h exp=%h", rcvd, get_out(), e);
                end
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(x, y, w));
                sent++;
                x = rnd_cpx(); y = rnd_cpx(); w = rnd_cpx();
            end
            @(posedge clk); #1;
        end
        drive(1'b0, x, y, w);
        nvec++;
        if (rcvd != sent || exp_q.size() != 0) begin
            nerr++; $display("FAIL rf_count got=%0d exp=%0d", rcvd, sent);
        end
    endtask

    task automatic test_reset_mid();
        cpx_t x, y, w;
        res_t got;
        int   lat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rnd_cpx(), rnd_cpx(), rnd_cpx());
            @(posedge clk); #1;
        end
        drive(1'b0, rnd_cpx(), rnd_cpx(), rnd_cpx());
        nvec++;
        if (bus.out_valid !== 1'b1) begin
            nerr++; $display("FAIL rm_pre got=%b exp=1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        nvec++;
        if (bus.out_valid !== 1'b0 || get_out() !== '0) begin
            nerr++; $display("FAIL rm_clear got=%b/%h exp=0/0", bus.out_valid, get_out());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nvec++;
            if (bus.out_valid !== 1'b0) begin
                nerr++; $display("FAIL rm_stale cyc=%0d got=%b exp=0", k, bus.out_valid);
            end
            @(posedge clk); #1;
        end
        x = rnd_cpx(); y = rnd_cpx(); w = rnd_cpx();
        run_single(x, y, w, got, lat);
        nvec++;
        if (lat !== 2) begin
            nerr++; $display("FAIL rm_latency got=%0d exp=2", lat);
        end
        nvec++;
        if (got !== model(x, y, w)) begin
            nerr++; $display("FAIL rm_data got=%h exp=%h", got, model(x, y, w));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_conj();
        test_sat();
        test_backpressure();
        test_back_to_back();
        test_random_flow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ifft_butterfly.md
# ifft_butterfly

Pipelined radix-2 inverse butterfly for the FFT datapath: accepts one complex pair (x, y) plus a twiddle W per transfer and produces top = (x + y·conj(W))/2 and bot = (x − y·conj(W))/2. It is the inverse-direction counterpart of the forward butterfly multiply stage. Data is Q16.16 signed fixed point throughout. It sits between the twiddle/sample sequencer and the output buffer, with valid/ready handshakes on both sides.

## Interface
- FRAC_BITS, 16: fractional bits of the Q format (1.0 = 0x00010000).
- DW, 32: data word width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input transfer request.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready.
- x_re, x_im  in  DW  upper input, signed Q16.16.
- y_re, y_im  in  DW  lower input, signed Q16.16.
- w_re, w_im  in  DW  twiddle, signed Q16.16 (block conjugates internally).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- top_re, top_im  out  DW  (x + t)/2.
- bot_re, bot_im  out  DW  (x − t)/2.
- sat  out  1  any component of t saturated for this result.

## Operation
- Clock domain: single, clk. Reset: rst, asynchronous, active-high.
- Stage 1 (multiply), registered:
  - t_re = y_re·w_re + y_im·w_im
  - t_im = y_im·w_re − y_re·w_im
  - Products are 64-bit signed; the sum or difference is held at 66 bits.
  - Arithmetic shift right by FRAC_BITS (truncation toward −∞).
  - Saturate to [0x80000000, 0x7FFFFFFF]. Per-component saturation flags are ORed into sat.
  - x is delayed alongside t.
- Stage 2 (add/scale), registered into the output registers:
  - top = (x + t) >>> 1 and bot = (x − t) >>> 1, computed at 33 bits.
  - Bits [32:1] are taken. The result cannot overflow, so no saturation is applied here.
  - Rounding is truncation toward −∞.
- Flow control:
  - Each stage has a valid bit: v1 for stage 1, and out_valid for stage 2.
  - advance = !out_valid || out_ready.
  - in_ready = advance. This is a combinational path from out_ready.
  - On advance: stage 1 loads the input, and v1 <= in_valid. Stage 2 loads stage 1, and out_valid <= v1.
  - When advance = 0, all registers hold. Output data and sat stay stable while out_valid && !out_ready.
- Ordering: strict FIFO. No result is dropped or duplicated.
- Reset values: out_valid=0, v1=0, sat=0, all data outputs 0. in_ready=1 after reset, since out_valid=0.
- Reset mid-operation: in-flight entries are discarded. There is no output on the cycle after reset deassertion.

## Timing
- Latency: 2 cycles from accepted input to out_valid, when out_ready is held high.
- Throughput: 1 transfer per cycle with out_ready=1.
- Capacity: 2 entries (stage 1 plus output). With out_ready=0, at most 2 inputs are accepted before in_ready drops. in_ready falls in the same cycle that out_valid=1 and out_ready=0.
- Simultaneous output consume and input accept in one cycle is legal and keeps full throughput.
- A bubble (in_valid=0) propagates as v1=0. out_valid then deasserts after the last result is consumed.

## Structure
- Shared package fft_pkg holds:
  - FRAC_BITS and DW.
  - Q16.16 constants ONE=0x00010000, SAT_MAX=0x7FFFFFFF, SAT_MIN=0x80000000.
  - A typedef for a complex Q16.16 pair.
- One sub-module, cmul_conj: combinational y·conj(W) with shift, saturation and sat flag. The top-level module holds the pipeline registers and the handshake.

## Test plan
- Basic: W=0x00010000+0j, x=0x00020000+0j, y=0x00010000+j0x00010000, out_ready=1. Required: 2 cycles later top=0x00018000+j0x00008000, bot=0x00008000+j0xFFFF8000, sat=0.
- Conjugation: W=0+j0x00010000, x=0, y=0x00010000+0j. Required: top=0+j0xFFFF8000, bot=0+j0x00008000.
- Saturation: y_re=0x7FFFFFFF, y_im=0, W=0x00020000+0j, x=0. Required: t_re saturates, top_re=0x3FFFFFFF, bot_re=0xC0000000, sat=1.
- Backpressure: stream 4 distinct inputs while out_ready=0 for 3 cycles, then 1. Required:
  - in_ready low once 2 entries are held.
  - Outputs stable while stalled.
  - All 4 results delivered in order with no loss or duplication.
- Full-rate stream: 16 back-to-back inputs with out_ready=1. Required: 16 outputs on consecutive cycles and in_ready always 1. Results must match a reference model with truncation toward −∞.
- Reset mid-stream: assert rst with 2 entries in flight. Required: out_valid=0 and all outputs 0 immediately. No stale result appears after release, and the next accepted input appears 2 cycles later.
